// File: rtl/soc_stream_pkg.sv
// -----------------------------------------------------------------------------
// soc_stream_pkg
// Shared definitions for the byte/word/block streaming family.
//   - bytes_per_word() / count_width(): size helpers for packers and
//     disassemblers (count_width covers the range 0..bytes inclusive).
//   - BYTES_PER_WORD: byte count of the default 32-bit word of 8-bit bytes.
//   - pack_state_e: accumulate / wait-to-flush state shared by the packer
//     and disassembler blocks.
// -----------------------------------------------------------------------------
package soc_stream_pkg;

  function automatic int bytes_per_word(input int wsize, input int bsize);
    return wsize / bsize;
  endfunction

  // One extra bit so that a full-word count (== bytes) is representable.
  function automatic int count_width(input int bytes);
    return $clog2(bytes) + 1;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(32, 8);

  typedef enum logic {
    ACCUM      = 1'b0,
    FLUSH_WAIT = 1'b1
  } pack_state_e;

endpackage

// File: rtl/byte_to_word_packer_if.sv
// -----------------------------------------------------------------------------
// byte_to_word_packer_if
// Byte-in / word-out stream bundle for byte_to_word_packer.
//   byte_in        byte from upstream
//   byte_in_ready  upstream has a valid byte
//   pull_byte      packer takes byte_in this edge (when byte_in_ready)
//   flush          single-cycle request to emit the partial word
//   word_out       packed word, first byte in the MSBs
//   word_bytes     valid byte count of word_out
//   word_ready     word_out is valid
//   word_out_hold  downstream stall
// Modports: master = stream environment (source + sink), slave = packer.
// -----------------------------------------------------------------------------
interface byte_to_word_packer_if #(
  parameter int WSIZE = 32,
  parameter int BSIZE = 8
);
  import soc_stream_pkg::*;

  localparam int CW = count_width(bytes_per_word(WSIZE, BSIZE));

  logic [BSIZE-1:0] byte_in;
  logic             byte_in_ready;
  logic             pull_byte;
  logic             flush;
  logic [WSIZE-1:0] word_out;
  logic [CW-1:0]    word_bytes;
  logic             word_ready;
  logic             word_out_hold;

  modport master (
    output byte_in,
    output byte_in_ready,
    output flush,
    output word_out_hold,
    input  pull_byte,
    input  word_out,
    input  word_bytes,
    input  word_ready
  );

  modport slave (
    input  byte_in,
    input  byte_in_ready,
    input  flush,
    input  word_out_hold,
    output pull_byte,
    output word_out,
    output word_bytes,
    output word_ready
  );

endinterface

// File: rtl/byte_to_word_packer_word_out_stage.sv
// -----------------------------------------------------------------------------
// word_out_stage
// Single-entry output register with ready/hold handshake.
//   clock, reset    rising-edge clock, async active-high reset
//   load            capture load_word/load_bytes this edge
//   load_word       word to capture
//   load_bytes      valid-byte count to capture
//   word_out_hold   downstream stall
//   word_out        registered word
//   word_bytes      registered byte count
//   word_ready      registered word is valid
//   out_free        stage is empty or draining this edge (safe to load)
// A transfer and a new load may share one edge, so the stage sustains one
// word per clock.
// -----------------------------------------------------------------------------
module word_out_stage #(
  parameter int W  = 32,
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [W-1:0]  load_word,
  input  logic [CW-1:0] load_bytes,
  input  logic          word_out_hold,
  output logic [W-1:0]  word_out,
  output logic [CW-1:0] word_bytes,
  output logic          word_ready,
  output logic          out_free
);

  assign out_free = !word_ready || !word_out_hold;

  // Output register stage: data stays frozen while held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_out   <= '0;
      word_bytes <= '0;
      word_ready <= 1'b0;
    end else if (load) begin
      word_out   <= load_word;
      word_bytes <= load_bytes;
      word_ready <= 1'b1;
    end else if (!word_out_hold) begin
      word_ready <= 1'b0;
    end
  end

endmodule

// File: rtl/byte_to_word_packer.sv
// -----------------------------------------------------------------------------
// byte_to_word_packer
// Packs a byte stream into WSIZE-bit words, first byte most significant, and
// presents each word on a ready/hold handshake. A flush emits the current
// partial word left-aligned and zero-padded, with its valid-byte count.
//   clock   rising-edge clock
//   reset   asynchronous, active-high; clears all state
//   bus     byte_to_word_packer_if.slave (byte side + word side)
// Parameters: WSIZE output word width (multiple of BSIZE, >= 2*BSIZE),
//             BSIZE input byte width.
// -----------------------------------------------------------------------------
module byte_to_word_packer #(
  parameter int WSIZE = 32,
  parameter int BSIZE = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  byte_to_word_packer_if.slave  bus
);
  import soc_stream_pkg::*;

  localparam int              BYTES    = bytes_per_word(WSIZE, BSIZE);
  localparam int              CW       = count_width(BYTES);
  localparam logic [CW-1:0]   LAST_IDX = CW'(BYTES - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(BYTES);

  // Move the n low-order bytes of the accumulator up to the MSBs, leaving
  // the unused low bytes zero.
  function automatic logic [WSIZE-1:0] align_partial(input logic [WSIZE-1:0] a,
                                                      input logic [CW-1:0]    n);
    logic [WSIZE-1:0] r;
    r = a;
    for (int i = 1; i < BYTES; i++) begin
      if (n == CW'(i)) r = a << ((BYTES - i) * BSIZE);
    end
    return r;
  endfunction

  pack_state_e      state, state_n;
  logic [WSIZE-1:0] acc, acc_n;
  logic [CW-1:0]    count, count_n;
  logic [WSIZE-1:0] shifted;
  logic [CW-1:0]    count_inc;
  logic             accept;
  logic             out_free;
  logic             load;
  logic [WSIZE-1:0] load_word;
  logic [CW-1:0]    load_bytes;
  logic [WSIZE-1:0] word_out_r;
  logic [CW-1:0]    word_bytes_r;
  logic             word_ready_r;

  assign shifted   = {acc[WSIZE-BSIZE-1:0], bus.byte_in};
  assign count_inc = count + CW'(1);

  // The accumulator can always take bytes below the last slot; the final
  // byte needs the output stage to be free because it bypasses acc.
  assign bus.pull_byte = !reset && (state == ACCUM) && ((count < LAST_IDX) || out_free);
  assign accept        = bus.byte_in_ready && bus.pull_byte;

  always_comb begin
    state_n    = state;
    acc_n      = acc;
    count_n    = count;
    load       = 1'b0;
    load_word  = '0;
    load_bytes = '0;
    case (state)
      ACCUM: begin
        if (accept && (count == LAST_IDX)) begin
          // Word completes: goes straight to the output stage. A flush in
          // the same cycle has nothing left to emit.
          load       = 1'b1;
          load_word  = shifted;
          load_bytes = FULL_CNT;
          acc_n      = '0;
          count_n    = '0;
        end else begin
          if (accept) begin
            acc_n   = shifted;
            count_n = count_inc;
          end
          // Same-cycle byte is folded in before the flush is evaluated.
          if (bus.flush && (count_n != '0)) begin
            if (out_free) begin
              load       = 1'b1;
              load_word  = align_partial(acc_n, count_n);
              load_bytes = count_n;
              acc_n      = '0;
              count_n    = '0;
            end else begin
              state_n = FLUSH_WAIT;
            end
          end
        end
      end
      FLUSH_WAIT: begin
        if (out_free) begin
          load       = 1'b1;
          load_word  = align_partial(acc, count);
          load_bytes = count;
          acc_n      = '0;
          count_n    = '0;
          state_n    = ACCUM;
        end
      end
      default: state_n = ACCUM;
    endcase
  end

  // Accumulator stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ACCUM;
      acc   <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      count <= count_n;
    end
  end

  // Output stage.
  word_out_stage #(
    .W  (WSIZE),
    .CW (CW)
  ) u_word_out_stage (
    .clock         (clock),
    .reset         (reset),
    .load          (load),
    .load_word     (load_word),
    .load_bytes    (load_bytes),
    .word_out_hold (bus.word_out_hold),
    .word_out      (word_out_r),
    .word_bytes    (word_bytes_r),
    .word_ready    (word_ready_r),
    .out_free      (out_free)
  );

  assign bus.word_out   = word_out_r;
  assign bus.word_bytes = word_bytes_r;
  assign bus.word_ready = word_ready_r;

endmodule
